// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, opcode field position, default widths.
// Also used by the control unit and the datapath.
package instr_fetch_unit_pkg;

  localparam int DEFAULT_ADDR_W  = 16;
  localparam int DEFAULT_INSTR_W = 16;

  localparam int OPC_W   = 4;
  localparam int OPC_MSB = DEFAULT_INSTR_W - 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch with a one-word prefetch buffer; a buffer hit loads ir at the same edge, a miss stalls for the memory latency.
// The memory request stays stable until mem_ack; a redirect during an outstanding request waits in DRAIN for the stale ack.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int INSTR_W = DEFAULT_INSTR_W
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               IRWrite,
  input  logic               PCWrite,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [OPC_W-1:0]   Opcode,
  output logic [ADDR_W-1:0]  fetch_pc,
  output logic               stall
);

  fetch_state_e       state;
  fetch_state_e       state_nxt;
  logic [ADDR_W-1:0]  pf_addr;
  logic [ADDR_W-1:0]  pf_addr_nxt;
  logic [ADDR_W-1:0]  pf_addr_inc;
  logic [INSTR_W-1:0] pf_buf;
  logic               ack_live;
  logic               word_avail;
  logic               consume;
  logic               redirect;
  logic               outstanding;

  assign pf_addr_inc = pf_addr + ADDR_W'(1);
  assign Opcode      = ir[INSTR_W-1 -: OPC_W];
  assign outstanding = (state == BUSY) || (state == DRAIN);

  always_comb begin
    ack_live    = mem_ack && (state == BUSY);
    word_avail  = (state == FULL) || ack_live;
    stall       = IRWrite && !word_avail;
    consume     = IRWrite && word_avail;
    pf_addr_nxt = consume ? pf_addr_inc : pf_addr;

    state_nxt = state;
    case (state)
      EMPTY:   state_nxt = BUSY;
      BUSY:    if (mem_ack) state_nxt = IRWrite ? EMPTY : FULL;
      FULL:    if (IRWrite) state_nxt = EMPTY;
      DRAIN:   if (mem_ack) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase

    // A PCWrite matching the sequential successor is the normal Fetch PC+1, not a branch.
    redirect = PCWrite && !stall && (pc_in != pf_addr_nxt);
    if (redirect) begin
      pf_addr_nxt = pc_in;
      state_nxt   = (outstanding && !mem_ack) ? DRAIN : EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= EMPTY;
      pf_addr  <= '0;
      pf_buf   <= '0;
      ir       <= '0;
      fetch_pc <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state   <= state_nxt;
      pf_addr <= pf_addr_nxt;

      if (ack_live && !IRWrite) begin
        pf_buf <= mem_rdata;
      end

      if (consume) begin
        ir       <= (state == FULL) ? pf_buf : mem_rdata;
        fetch_pc <= pf_addr;
      end

      if ((state == EMPTY) && (state_nxt == BUSY)) begin
        mem_req  <= 1'b1;
        mem_addr <= pf_addr;
      end else if (outstanding && mem_ack) begin
        mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and prefetch stage sitting directly upstream of the multi-cycle control unit. It fetches 16-bit instructions from instruction memory over a req/ack handshake and holds one prefetched word. On the control unit's IRWrite it loads the instruction register and presents `Opcode`. It raises `stall` whenever the requested instruction is not yet available, and discards stale prefetches when a PCWrite redirects the PC.

## Interface
- `ADDR_W`, 16: word-address width of PC and memory.
- `INSTR_W`, 16: instruction width; `Opcode` is `ir[INSTR_W-1 -: 4]`.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `IRWrite`  in  1  control unit requests the next instruction into `ir`.
- `PCWrite`  in  1  control unit writes a new PC; `pc_in` is valid this cycle.
- `pc_in`  in  ADDR_W  new PC value.
- `mem_req`  out  1  instruction-memory read request, held high until `mem_ack`.
- `mem_addr`  out  ADDR_W  read address, stable while `mem_req` is high.
- `mem_ack`  in  1  `mem_rdata` is valid this cycle; completes the request.
- `mem_rdata`  in  INSTR_W  instruction word.
- `ir`  out  INSTR_W  current instruction register.
- `Opcode`  out  4  top four bits of `ir`, feeding the control unit.
- `fetch_pc`  out  ADDR_W  address of the instruction held in `ir`.
- `stall`  out  1  combinational; IRWrite cannot be satisfied this cycle, and the control unit holds its state.

## Operation
- Internal registers: `pf_addr` (prefetch address), `pf_buf`, and a state register with states EMPTY, BUSY, FULL, DRAIN.
- Reset: state EMPTY, `pf_addr`=0, `pf_buf`=0, `ir`=0 (so `Opcode`=0), `fetch_pc`=0, `mem_req`=0, `mem_addr`=0. `stall` follows IRWrite (1 if IRWrite=1).
- EMPTY → BUSY unconditionally. `mem_req` goes to 1 and `mem_addr` goes to `pf_addr` at that edge.
- BUSY: `mem_req`=1.
  - On `mem_ack` without IRWrite: `pf_buf`←`mem_rdata`, → FULL.
  - On `mem_ack` with IRWrite (bypass): `ir`←`mem_rdata`, `fetch_pc`←`pf_addr`, `pf_addr`←`pf_addr`+1, → EMPTY; `stall`=0.
  - Without `mem_ack`: `stall`=IRWrite.
- FULL: `mem_req`=0. On IRWrite: `ir`←`pf_buf`, `fetch_pc`←`pf_addr`, `pf_addr`←`pf_addr`+1, → EMPTY; `stall`=0.
- DRAIN: `mem_req`=1 at the stale address. `stall`=IRWrite. On `mem_ack` the data is discarded, → EMPTY.
- Redirect: evaluated after the IRWrite effect in the same cycle, and only when `stall`=0.
  - If PCWrite=1 and `pc_in` ≠ post-IRWrite `pf_addr`: `pf_addr`←`pc_in`.
  - Any buffered word is dropped. Next state is DRAIN if a request is still outstanding without an ack this cycle, otherwise EMPTY.
  - If `pc_in` equals `pf_addr` (the sequential PC+1 from Fetch), there is no flush.
- PCWrite while `stall`=1 is ignored; the control unit reasserts it.
- `pf_addr`+1 wraps modulo 2^ADDR_W: 0xFFFF → 0x0000.
- `mem_addr` and `mem_req` are never changed while a request is outstanding (BUSY/DRAIN), redirect included.
- Reset mid-request: the unit returns to EMPTY with `mem_req`=0. A late `mem_ack` arriving in EMPTY or FULL is ignored.

## Timing
- Prefetch hit (FULL plus IRWrite): `ir` updates at the same edge, zero stall cycles.
- Miss: `stall` stays high until the `mem_ack` cycle, then `ir` loads at that edge. Stall cycles equal memory latency.
- After a consume, the next request issues 1 cycle later (EMPTY takes one cycle). Sequential refill costs 1 + memory latency cycles.
- Redirect costs 1 cycle (EMPTY) plus any DRAIN wait plus memory latency before the target instruction is available.

## Structure
- Shared package holds:
  - the state enum (EMPTY=0, BUSY=1, FULL=2, DRAIN=3);
  - opcode field position constants (`OPC_W`=4, `OPC_MSB`=INSTR_W-1);
  - `ADDR_W`/`INSTR_W` defaults, shared with the control unit and the datapath.
- No sub-module. The block is a single flat FSM plus registers; the buffer is one word and does not justify a FIFO instance.

## Test plan
- Reset, then memory with 2-cycle ack latency: `mem_req` rises at cycle 1 with `mem_addr`=0x0000. IRWrite held from cycle 1 gives `stall`=1 for 2 cycles; `ir` becomes word[0] and `fetch_pc`=0.
- Prefetch hit: `pf_buf` holds 0xB123 at 0x0004 in FULL; IRWrite plus PCWrite with `pc_in`=0x0005 gives `stall`=0, `ir`=0xB123, `Opcode`=0xB, no flush, and the next `mem_addr`=0x0005.
- Redirect in BUSY without ack (addr 0x0010): PCWrite with `pc_in`=0x0040 gives DRAIN. The 0x0010 data is discarded on ack, and the next request is `mem_addr`=0x0040.
- Bypass: in BUSY, `mem_ack` and IRWrite in the same cycle with `mem_rdata`=0x7ABC give `stall`=0 and `ir`=0x7ABC at that edge.
- Wrap: consume at `pf_addr`=0xFFFF; the next `mem_addr` is 0x0000.
- Reset asserted in BUSY gives `mem_req`=0 next cycle and `ir`=0. A `mem_ack` one cycle later is ignored, and the fetch restarts at 0x0000.
